// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
//   fetch_state_e : fetch sequencer state (BOOT, RUN, HALT)
//   FETCH_DEPTH   : entries in the fetch buffer queue
//   INSTR_BYTES   : bytes per instruction word (PC increment)
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    localparam int unsigned FETCH_DEPTH = 2;
    localparam int unsigned INSTR_BYTES = 4;

endpackage : fetch_pkg

// File: rtl/fetch_fifo.sv
// fetch_fifo: 2-entry {pc, instr} queue between instruction memory and decode.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   push, push_pc,
//   push_instr        : enqueue one fetched word with its PC
//   pop               : dequeue the head (ignored when empty)
//   flush             : discard all entries; wins over push and pop
//   count             : number of valid entries (0..2)
//   head_pc,
//   head_instr        : head entry contents (meaningful only when count != 0)
// The producer guarantees push never occurs while full without a pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [ADDR_WIDTH-1:0] push_pc,
    input  logic [DATA_WIDTH-1:0] push_instr,
    input  logic                  pop,
    input  logic                  flush,
    output logic [1:0]            count,
    output logic [ADDR_WIDTH-1:0] head_pc,
    output logic [DATA_WIDTH-1:0] head_instr
);

    logic [ADDR_WIDTH-1:0] pc_q    [FETCH_DEPTH];
    logic [ADDR_WIDTH-1:0] pc_d    [FETCH_DEPTH];
    logic [DATA_WIDTH-1:0] instr_q [FETCH_DEPTH];
    logic [DATA_WIDTH-1:0] instr_d [FETCH_DEPTH];
    logic                  rd_ptr_q, rd_ptr_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic [1:0]            count_q, count_d;

    always_comb begin
        pc_d     = pc_q;
        instr_d  = instr_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = '0;
        end else begin
            if (pop && (count_q != '0)) begin
                rd_ptr_d = ~rd_ptr_q;
                count_d  = count_d - 2'd1;
            end
            if (push) begin
                pc_d[wr_ptr_q]    = push_pc;
                instr_d[wr_ptr_q] = push_instr;
                wr_ptr_d          = ~wr_ptr_q;
                count_d           = count_d + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < FETCH_DEPTH; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
            end
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count      = count_q;
    assign head_pc    = pc_q[rd_ptr_q];
    assign head_instr = instr_q[rd_ptr_q];

endmodule : fetch_fifo

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the PC, issues word fetches to a
// synchronous 1-cycle-latency instruction memory, buffers returned words in a
// 2-entry queue and takes branch redirects (target = branch_pc + ImmOp).
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   imem_en, imem_addr           : fetch request / word-aligned address
//   imem_rdata                   : word for the address issued last cycle
//   instr, instr_pc, instr_valid : queue head to decode (zero when invalid)
//   instr_ready                  : decode consumes the head this cycle
//   PCsrc, branch_pc, ImmOp      : redirect pulse, branch PC, sign-extended offset
//   misalign                     : sticky misaligned-target flag
// Build option FETCH_MISALIGN_TRAP_EN: a redirect to a non-word-aligned target
// halts fetch and sets misalign until reset. Without it the low target bits
// are cleared and misalign is tied low.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_en,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    input  logic                  PCsrc,
    input  logic [ADDR_WIDTH-1:0] branch_pc,
    input  logic [DATA_WIDTH-1:0] ImmOp,
    output logic                  misalign
);

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    // inflight_q: a live (not killed) request was issued last cycle, so
    // imem_rdata this cycle belongs to inflight_pc_q.
    logic                  inflight_q, inflight_d;
    logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;

    logic [1:0]            fifo_count;
    logic [ADDR_WIDTH-1:0] head_pc;
    logic [DATA_WIDTH-1:0] head_instr;
    logic                  fifo_push;
    logic                  fifo_flush;
    logic                  pop;
    logic                  active;
    logic                  redirect;
    logic [2:0]            occupancy;
    logic [ADDR_WIDTH-1:0] target;

    assign instr_valid = (fifo_count != '0);
    assign instr       = instr_valid ? head_instr : '0;
    assign instr_pc    = instr_valid ? head_pc    : '0;
    assign pop         = instr_valid & instr_ready;

    assign active    = (state_q != HALT);
    assign redirect  = PCsrc & active;
    assign target    = branch_pc + ImmOp[ADDR_WIDTH-1:0];

    // Slots already committed (buffered + returning) minus the one leaving
    // this cycle must leave room for one more word.
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q};
    assign imem_en   = !rst && active && (occupancy < (3'd2 + {2'b00, pop}));
    assign imem_addr = fetch_pc_q;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;
    assign misalign = misalign_q;
`else
    assign misalign = 1'b0;
`endif

    // A request issued in the redirect cycle is never marked in flight, so
    // its response is dropped just like the one already returning.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        fifo_push     = inflight_q;
        fifo_flush    = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        misalign_d    = misalign_q;
`endif
        if (state_q == BOOT) begin
            state_d = RUN;
        end
        if (redirect) begin
            fifo_flush = 1'b1;
            fifo_push  = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (target[1:0] != 2'b00) begin
                state_d    = HALT;
                misalign_d = 1'b1;
            end else begin
                fetch_pc_d = target;
            end
`else
            fetch_pc_d = target & ~ADDR_WIDTH'(INSTR_BYTES - 1);
`endif
        end else if (imem_en) begin
            inflight_d    = 1'b1;
            inflight_pc_d = fetch_pc_q;
            fetch_pc_d    = fetch_pc_q + ADDR_WIDTH'(INSTR_BYTES);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= BOOT;
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_q    <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_q    <= misalign_d;
`endif
        end
    end

    fetch_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_pc   (inflight_pc_q),
        .push_instr(imem_rdata),
        .pop       (pop),
        .flush     (fifo_flush),
        .count     (fifo_count),
        .head_pc   (head_pc),
        .head_instr(head_instr)
    );

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit. A queue-based reference
// model tracks buffered PCs, the returning fetch and the next fetch PC; the
// instruction memory returns a fixed hash of the requested address.
// Honours FETCH_MISALIGN_TRAP_EN when the design is built with it.
module tb_fetch_unit;

    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 32;
    localparam logic [31:0] RPC = 32'h0;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          imem_en;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_rdata = '0;
    logic [DW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          instr_valid;
    logic          instr_ready = 1'b0;
    logic          PCsrc = 1'b0;
    logic [AW-1:0] branch_pc = '0;
    logic [DW-1:0] ImmOp = '0;
    logic          misalign;

    always #5 clk = ~clk;

    fetch_unit #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .RESET_PC  (RPC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_en    (imem_en),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .PCsrc      (PCsrc),
        .branch_pc  (branch_pc),
        .ImmOp      (ImmOp),
        .misalign   (misalign)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // Reference model: mode 0 = booting, 1 = running, 2 = halted.
    logic [31:0] mq[$];
    bit          m_inflight;
    logic [31:0] m_inflight_pc;
    logic [31:0] m_fetch_pc;
    int          m_mode;
    bit          m_mis;
    logic        prev_en   = 1'b0;
    logic [31:0] prev_addr = '0;

    task automatic model_reset();
        mq.delete();
        m_inflight    = 1'b0;
        m_inflight_pc = '0;
        m_fetch_pc    = RPC;
        m_mode        = 0;
        m_mis         = 1'b0;
    endtask

    // One clock cycle: drive inputs, compare against the model, advance it.
    task automatic cyc(input bit r, input bit rdy, input bit br,
                       input logic [31:0] bpc, input logic [31:0] imm);
        bit          e_valid, e_pop, e_en;
        int          occ;
        logic [31:0] t;
        @(negedge clk);
        rst         = r;
        instr_ready = rdy;
        PCsrc       = br;
        branch_pc   = bpc;
        ImmOp       = imm;
        imem_rdata  = prev_en ? mem_word(prev_addr) : 32'hBAD0_BAD0;
        #1;
        e_valid = (mq.size() != 0);
        e_pop   = e_valid && rdy;
        occ     = mq.size() + int'(m_inflight) - int'(e_pop);
        e_en    = !r && (m_mode != 2) && (occ < 2);
        check_eq("instr_valid", instr_valid, e_valid);
        check_eq("instr_pc", instr_pc, e_valid ? mq[0] : 32'h0);
        check_eq("instr", instr, e_valid ? mem_word(mq[0]) : 32'h0);
        check_eq("imem_en", imem_en, e_en);
        check_eq("imem_addr", imem_addr, m_fetch_pc);
        check_eq("misalign", misalign, m_mis);
        prev_en   = imem_en;
        prev_addr = imem_addr;
        if (r) begin
            model_reset();
        end else begin
            if (e_pop) void'(mq.pop_front());
            if (br && m_mode != 2) begin
                mq.delete();
                m_inflight = 1'b0;
                t = bpc + imm;
`ifdef FETCH_MISALIGN_TRAP_EN
                if (t[1:0] != 2'b00) begin
                    m_mode = 2;
                    m_mis  = 1'b1;
                end else begin
                    m_fetch_pc = t;
                    m_mode     = 1;
                end
`else
                m_fetch_pc = t & 32'hFFFF_FFFC;
                m_mode     = 1;
`endif
            end else begin
                if (m_inflight) mq.push_back(m_inflight_pc);
                m_inflight = e_en;
                if (e_en) begin
                    m_inflight_pc = m_fetch_pc;
                    m_fetch_pc    = m_fetch_pc + 32'd4;
                end
                if (m_mode == 0) m_mode = 1;
            end
        end
    endtask

    task automatic idle(input bit rdy, input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, rdy, 1'b0, '0, '0);
    endtask

    initial begin
        bit          r, rdy, br;
        logic [31:0] bpc, imm;

        model_reset();
        repeat (2) @(posedge clk);

        // Reset values, then streaming from RESET_PC.
        cyc(1'b1, 1'b1, 1'b0, '0, '0);
        check_eq("rst_en", imem_en, 1'b0);
        check_eq("rst_addr", imem_addr, RPC);
        check_eq("rst_valid", instr_valid, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, '0, '0);
        check_eq("boot_en", imem_en, 1'b1);
        check_eq("boot_addr", imem_addr, RPC);
        cyc(1'b0, 1'b1, 1'b0, '0, '0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 1'b0, '0, '0);
            check_eq("stream_valid", instr_valid, 1'b1);
            check_eq("stream_pc", instr_pc, RPC + 32'(4 * i));
        end

        // Stall: two words buffered, no issue, head stable; then drain in order.
        cyc(1'b1, 1'b1, 1'b0, '0, '0);
        idle(1'b1, 2);
        idle(1'b0, 1);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 1'b0, '0, '0);
            check_eq("stall_en", imem_en, 1'b0);
            check_eq("stall_pc", instr_pc, RPC);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 1'b0, '0, '0);
            check_eq("drain_pc", instr_pc, RPC + 32'(4 * i));
        end

        // Backward branch: 0x10 + (-8) -> 0x08, visible three cycles later.
        idle(1'b1, 2);
        cyc(1'b0, 1'b1, 1'b1, 32'h10, 32'hFFFF_FFF8);
        cyc(1'b0, 1'b1, 1'b0, '0, '0);
        check_eq("br_addr", imem_addr, 32'h08);
        check_eq("br_gap1", instr_valid, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, '0, '0);
        check_eq("br_gap2", instr_valid, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, '0, '0);
        check_eq("br_pc", instr_pc, 32'h08);

        // Redirect together with a pop while the queue is full.
        idle(1'b0, 3);
        check_eq("full_en", imem_en, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 32'h40, 32'h20);
        idle(1'b1, 2);
        check_eq("fullbr_gap", instr_valid, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, '0, '0);
        check_eq("fullbr_pc", instr_pc, 32'h60);
        cyc(1'b0, 1'b1, 1'b0, '0, '0);
        check_eq("fullbr_pc2", instr_pc, 32'h64);

        // Misaligned target 0x100 + 6.
        cyc(1'b0, 1'b1, 1'b1, 32'h100, 32'h6);
`ifdef FETCH_MISALIGN_TRAP_EN
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 32'h200, 32'h0);
            check_eq("mis_flag", misalign, 1'b1);
            check_eq("mis_en", imem_en, 1'b0);
        end
`else
        idle(1'b1, 2);
        cyc(1'b0, 1'b1, 1'b0, '0, '0);
        check_eq("mis_off_pc", instr_pc, 32'h104);
`endif

        // Reset right after a redirect.
        cyc(1'b1, 1'b1, 1'b0, '0, '0);
        idle(1'b1, 3);
        cyc(1'b0, 1'b1, 1'b1, 32'h200, 32'h10);
        cyc(1'b1, 1'b1, 1'b0, '0, '0);
        cyc(1'b1, 1'b1, 1'b0, '0, '0);
        check_eq("rst2_valid", instr_valid, 1'b0);
        check_eq("rst2_addr", imem_addr, RPC);
        check_eq("rst2_mis", misalign, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, '0, '0);
        check_eq("rst2_first", imem_addr, RPC);
        check_eq("rst2_first_en", imem_en, 1'b1);

        // Randomised traffic, including wrap-around targets and resets.
        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 199) == 0) || (m_mode == 2 && $urandom_range(0, 3) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            br  = ($urandom_range(0, 19) == 0);
            bpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
            imm = 32'($urandom_range(0, 1023)) - 32'd512;
            if ($urandom_range(0, 3) != 0) imm = imm & 32'hFFFF_FFFC;
            cyc(r, rdy, br, bpc, imm);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_fetch_unit
